// File: rtl/systolic_input_feeder_pkg.sv
// Shared types for the systolic input feeder: element/vector types and the feeder FSM states.
package systolic_input_feeder_pkg;

  localparam int FEEDER_DATA_W = 16;

  typedef logic signed [FEEDER_DATA_W-1:0] data_t;

  typedef struct packed {
    data_t x1;
    data_t x2;
  } vec_t;

  typedef enum logic [2:0] {
    FILL,
    ARMED,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;

endpackage

// File: rtl/systolic_input_feeder_sync_fifo.sv
// Synchronous FIFO for one batch of packed {x1,x2} vectors; head is visible combinationally.
// Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
module systolic_input_feeder_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Buffers a batch of {x1,x2} vectors, then on go streams them into the 2x2 array with row 2
// lagging row 1 by one cycle; all array-facing outputs are registered.
module systolic_input_feeder
  import systolic_input_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x1,
  input  logic signed [DATA_W-1:0] in_x2,
  input  logic                     in_last,
  input  logic                     go,
  output logic signed [DATA_W-1:0] input_11,
  output logic signed [DATA_W-1:0] input_21,
  output logic                     start,
  output logic                     armed,
  output logic                     busy,
  output logic                     done,
  output logic [CW-1:0]            count
);

  feeder_state_e state_q, state_d;

  logic signed [DATA_W-1:0] in11_q, in11_d;
  logic signed [DATA_W-1:0] in21_q, in21_d;
  logic signed [DATA_W-1:0] skew_q, skew_d;
  logic start_q, start_d;
  logic armed_q, armed_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic                     push, pop;
  logic [2*DATA_W-1:0]      head;
  logic signed [DATA_W-1:0] head_x1, head_x2;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_full, fifo_empty;

  systolic_input_feeder_sync_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({in_x1, in_x2}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_x1  = head[2*DATA_W-1:DATA_W];
  assign head_x2  = head[DATA_W-1:0];
  assign in_ready = (state_q == FILL) && !fifo_full;
  assign push     = in_valid && in_ready;

  // Registered outputs describe the cycle being entered: the go edge already presents k=0.
  always_comb begin
    state_d = state_q;
    in11_d  = '0;
    in21_d  = '0;
    skew_d  = skew_q;
    start_d = 1'b0;
    armed_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      FILL: begin
        if (push && (in_last || fifo_count == CW'(DEPTH-1))) begin
          state_d = ARMED;
          armed_d = 1'b1;
        end
      end
      ARMED: begin
        armed_d = 1'b1;
        if (go) begin
          state_d = STREAM;
          armed_d = 1'b0;
          pop     = 1'b1;
          in11_d  = head_x1;
          in21_d  = '0;
          skew_d  = head_x2;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      STREAM: begin
        start_d = 1'b1;
        busy_d  = 1'b1;
        in21_d  = skew_q;
        if (!fifo_empty) begin
          pop    = 1'b1;
          in11_d = head_x1;
          skew_d = head_x2;
        end else begin
          state_d = DRAIN;
          skew_d  = '0;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      in11_q  <= '0;
      in21_q  <= '0;
      skew_q  <= '0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in11_q  <= in11_d;
      in21_q  <= in21_d;
      skew_q  <= skew_d;
      start_q <= start_d;
      armed_q <= armed_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign input_11 = in11_q;
  assign input_21 = in21_q;
  assign start    = start_q;
  assign armed    = armed_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = fifo_count;

endmodule
